lfsr_seq_ctrl: RTL and testbench

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

---
 rtl/lfsr_pkg.sv | 32 +++
 rtl/lfsr_core.sv | 36 +++
 rtl/lfsr_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR burst sequencer: FSM state encoding,
// default seed/taps and the Fibonacci advance function used by core and controller.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int          LFSR_WIDTH_DEF = 22;
  localparam int          TAP_A_DEF      = 21;
  localparam int          TAP_B_DEF      = 20;
  localparam logic [21:0] SEED_DEF       = 22'h2FFFFF;

  // Shift left by one and feed tap_a ^ tap_b into bit 0; the result is masked
  // to 'width' bits so one function serves every instance width up to 64.
  function automatic logic [63:0] lfsr_advance(input logic [63:0] s,
                                               input int          width,
                                               input int          tap_a,
                                               input int          tap_b);
    logic [63:0] mask;
    logic [5:0]  ia;
    logic [5:0]  ib;
    ia   = tap_a[5:0];
    ib   = tap_b[5:0];
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return ((s << 1) | {63'd0, s[ia] ^ s[ib]}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Shift register of the sequencer: loads a seed, or advances one step per
// 'step' pulse using lfsr_pkg::lfsr_advance; otherwise holds.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH_DEF,
  parameter int TAP_A = TAP_A_DEF,
  parameter int TAP_B = TAP_B_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;

  assign w_next = WIDTH'(lfsr_advance(64'(r_state), WIDTH, TAP_A, TAP_B));

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
    end else if (load) begin
      r_state <= seed;
    end else if (step) begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Burst controller around lfsr_core: IDLE/LOAD/RUN/DONE FSM, burst counter and
// valid/ready output. Optional period checker enabled by LFSR_SEQ_CTRL_PERIOD_CHK_EN.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_WIDTH_DEF,
  parameter int               TAP_A = TAP_A_DEF,
  parameter int               TAP_B = TAP_B_DEF,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEF),
  parameter int               LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    seed_sel,
  input  logic [WIDTH-1:0]        seed_in,
  input  logic [LEN_W-1:0]        burst_len,
  input  logic                    abort,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    busy,
`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
  output logic                    done,
  output logic                    cycle,
  output logic [WIDTH-1:0]        period_len
`else
  output logic                    done
`endif
);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_seed;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_remain;
  logic [WIDTH-1:0] w_lfsr;
  logic             w_accept_start;
  logic             w_load;
  logic             w_step;

  assign w_accept_start = (r_state == ST_IDLE) && start && !abort;
  assign w_load         = (r_state == ST_LOAD) && !abort;
  // Abort wins over a simultaneous handshake: no advance, no decrement.
  assign w_step         = (r_state == ST_RUN) && out_ready && !abort;

  lfsr_core #(
    .WIDTH(WIDTH),
    .TAP_A(TAP_A),
    .TAP_B(TAP_B)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .load (w_load),
    .seed (r_seed),
    .step (w_step),
    .state(w_lfsr)
  );

  // NOTE: next state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept_start) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (w_step && (r_remain == LEN_W'(1))) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Seed choice and length are captured with start; a zero external seed
  // would lock the LFSR, so it falls back to SEED.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_seed   <= '0;
      r_len    <= '0;
      r_remain <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept_start) begin
        r_seed <= (seed_sel && (seed_in != '0)) ? seed_in : SEED;
        r_len  <= burst_len;
      end
      if (w_load) begin
        r_remain <= r_len;
      end else if (w_step && (r_remain != '0)) begin
        r_remain <= r_remain - 1'b1;
      end
    end
  end

  assign out_valid = (r_state == ST_RUN);
  assign out_data  = out_valid ? $signed(w_lfsr) : '0;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE) && !abort;

`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
  logic [WIDTH-1:0] r_adv_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_cycle;
  logic [WIDTH-1:0] w_lfsr_next;

  assign w_lfsr_next = WIDTH'(lfsr_advance(64'(w_lfsr), WIDTH, TAP_A, TAP_B));

  // The count restarts on each return to the seed so period_len stays one period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_adv_cnt <= '0;
      r_period  <= '0;
      r_cycle   <= 1'b0;
    end else begin
      r_cycle <= 1'b0;
      if (w_load) begin
        r_adv_cnt <= '0;
      end else if (w_step) begin
        if (w_lfsr_next == r_seed) begin
          r_cycle   <= 1'b1;
          r_period  <= r_adv_cnt + 1'b1;
          r_adv_cnt <= '0;
        end else begin
          r_adv_cnt <= r_adv_cnt + 1'b1;
        end
      end
    end
  end

  assign cycle      = r_cycle;
  assign period_len = r_period;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: table of per-cycle input/expected-output
// records, plus hand-written continuous-burst and period-check sequences.
module tb_lfsr_seq_ctrl;

  localparam logic        L = 1'b0;
  localparam logic        H = 1'b1;
  localparam logic [21:0] Z = 22'h0;
  localparam logic [21:0] S = 22'h2FFFFF;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               seed_sel;
  logic [21:0]        seed_in;
  logic [15:0]        burst_len;
  logic               abort;
  logic               out_ready;
  logic               out_valid;
  logic signed [21:0] out_data;
  logic               busy;
  logic               done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
  logic        m_cycle;
  logic [21:0] m_period;
  logic        p_start;
  logic        p_valid;
  logic signed [3:0] p_data;
  logic        p_busy;
  logic        p_done;
  logic        p_cycle;
  logic [3:0]  p_period;
`endif

  lfsr_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seed_sel  (seed_sel),
    .seed_in   (seed_in),
    .burst_len (burst_len),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
    .done      (done),
    .cycle     (m_cycle),
    .period_len(m_period)
`else
    .done      (done)
`endif
  );

`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
  lfsr_seq_ctrl #(
    .WIDTH(4),
    .TAP_A(3),
    .TAP_B(2),
    .SEED (4'hF)
  ) dut_p4 (
    .clk       (clk),
    .reset     (reset),
    .start     (p_start),
    .seed_sel  (1'b0),
    .seed_in   (4'h0),
    .burst_len (16'd0),
    .abort     (1'b0),
    .out_ready (1'b1),
    .out_valid (p_valid),
    .out_data  (p_data),
    .busy      (p_busy),
    .done      (p_done),
    .cycle     (p_cycle),
    .period_len(p_period)
  );
`endif

  typedef struct {
    logic        rst;
    logic        start;
    logic        sel;
    logic [21:0] seed;
    logic [15:0] len;
    logic        abort;
    logic        ready;
    logic        ev;
    logic [21:0] ed;
    logic        eb;
    logic        edn;
  } vec_t;

  function automatic vec_t mk(logic rst, logic st, logic sel, logic [21:0] seed,
                              logic [15:0] len, logic ab, logic rdy,
                              logic ev, logic [21:0] ed, logic eb, logic edn);
    vec_t v;
    v.rst = rst; v.start = st; v.sel = sel; v.seed = seed; v.len = len;
    v.abort = ab; v.ready = rdy; v.ev = ev; v.ed = ed; v.eb = eb; v.edn = edn;
    return v;
  endfunction

  function automatic logic [21:0] ref_adv(logic [21:0] s);
    return {s[20:0], s[21] ^ s[20]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle's inputs, check the outputs of that same cycle, then step the clock.
  task automatic step(input vec_t v, input string tag);
    reset     = v.rst;
    start     = v.start;
    seed_sel  = v.sel;
    seed_in   = v.seed;
    burst_len = v.len;
    abort     = v.abort;
    out_ready = v.ready;
    #1;
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v.ev});
    check({tag, ".data"},  {10'd0, $unsigned(out_data)}, {10'd0, v.ed});
    check({tag, ".busy"},  {31'd0, busy}, {31'd0, v.eb});
    check({tag, ".done"},  {31'd0, done}, {31'd0, v.edn});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t        vecs[$];
  logic [21:0] m;

  initial begin
    reset = 1'b1; start = 1'b0; seed_sel = 1'b0; seed_in = '0;
    burst_len = '0; abort = 1'b0; out_ready = 1'b0;
`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
    p_start = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", {31'd0, out_valid}, 32'd0);
    check("reset.data",  {10'd0, $unsigned(out_data)}, 32'd0);
    check("reset.busy",  {31'd0, busy}, 32'd0);
    check("reset.done",  {31'd0, done}, 32'd0);

    // Default seed, burst of 4, always ready.
    vecs.push_back(mk(L,H,L,Z,16'd4,L,H, L,Z,L,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,S,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,22'h1FFFFF,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,22'h3FFFFF,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,22'h3FFFFE,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,H,H));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,L,L));
    // Abort in IDLE together with start: nothing happens.
    vecs.push_back(mk(L,H,L,Z,16'd4,H,H, L,Z,L,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,L,L));
    // Burst of 3 with ready 1,0,0,1,1 and a stray start while busy.
    vecs.push_back(mk(L,H,L,Z,16'd3,L,L, L,Z,L,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,L, L,Z,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,S,H,L));
    vecs.push_back(mk(L,H,L,Z,16'd0,L,L, H,22'h1FFFFF,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,L, H,22'h1FFFFF,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,22'h1FFFFF,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,22'h3FFFFF,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,H,H));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,L,L));
    // External seed 0 falls back to SEED; seed 1 runs 1, 2; abort in DONE kills the pulse.
    vecs.push_back(mk(L,H,H,Z,16'd1,L,H, L,Z,L,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,S,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,H,H));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,L,L));
    vecs.push_back(mk(L,H,H,22'h1,16'd2,L,H, L,Z,L,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,22'h000001,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,22'h000002,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,H,H, L,Z,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,L,L));
    // Abort in LOAD.
    vecs.push_back(mk(L,H,L,Z,16'd5,L,H, L,Z,L,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,H,H, L,Z,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,L,L));
    // Abort with simultaneous handshake at the last sample: no done.
    vecs.push_back(mk(L,H,L,Z,16'd1,L,H, L,Z,L,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,H,H, H,S,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,L,L));
    // Reset mid-RUN with a stray start held alongside it.
    vecs.push_back(mk(L,H,L,Z,16'd0,L,H, L,Z,L,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, H,S,H,L));
    vecs.push_back(mk(L,H,L,Z,16'd0,L,H, H,22'h1FFFFF,H,L));
    vecs.push_back(mk(H,H,L,Z,16'd0,L,H, H,22'h3FFFFF,H,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,L,L));
    vecs.push_back(mk(L,L,L,Z,16'd0,L,H, L,Z,L,L));

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Continuous burst, abort on the 10th RUN cycle, then immediate restart.
    step(mk(L,H,L,Z,16'd0,L,H, L,Z,L,L), "cont.start");
    step(mk(L,L,L,Z,16'd0,L,H, L,Z,H,L), "cont.load");
    m = S;
    for (int i = 1; i <= 10; i++) begin
      step(mk(L,L,L,Z,16'd0,(i == 10) ? H : L,H, H,m,H,L), $sformatf("cont.run%0d", i));
      m = ref_adv(m);
    end
    step(mk(L,H,L,Z,16'd0,L,H, L,Z,L,L), "cont.after_abort");
    step(mk(L,L,L,Z,16'd0,L,H, L,Z,H,L), "cont.reload");
    step(mk(L,L,L,Z,16'd0,L,H, H,S,H,L), "cont.rerun");
    step(mk(L,L,L,Z,16'd0,H,H, H,22'h1FFFFF,H,L), "cont.abort2");
    step(mk(L,L,L,Z,16'd0,L,H, L,Z,L,L), "cont.idle");

`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
    p_start = 1'b1;
    @(posedge clk);
    #1;
    p_start = 1'b0;
    for (int i = 0; i < 100 && !p_cycle; i++) begin
      @(posedge clk);
      #1;
    end
    check("p4.cycle_seen", {31'd0, p_cycle}, 32'd1);
    check("p4.period_len", {28'd0, p_period}, 32'd15);
    @(posedge clk);
    #1;
    check("p4.cycle_one_shot", {31'd0, p_cycle}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
